npc_mc_seq: RTL and testbench

Multi-cycle sequencer for the next NPC generation. It replaces the single-cycle fetch/execute loop with a valid/ready bus shared by instruction fetch and load/store.
- Owns the PC, the instruction register, and bus arbitration.
- Gates register-file writeback, counts wait cycles for bus timeout, and raises traps and halt.
- Sits between the IDU/EXU/CSR datapath and one memory bus port.

---
 rtl/npc_pkg.sv | 23 ++
 rtl/npc_mc_seq_if.sv | 24 ++
 rtl/npc_bus_watchdog.sv | 32 +++
 rtl/npc_mc_seq.sv | 175 +++++++++++++++++
 tb/tb_npc_mc_seq.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the multi-cycle NPC sequencer.
package npc_pkg;

  // Sequencer states; one bus transaction in flight at most.
  typedef enum logic [2:0] {
    StFetchReq,
    StFetchWait,
    StExec,
    StMemReq,
    StMemWait,
    StWb,
    StHalt
  } state_e;

  // mcause codes raised by the sequencer itself.
  localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_IFAULT    = 4'd1;
  localparam logic [3:0] CAUSE_LFAULT    = 4'd5;
  localparam logic [3:0] CAUSE_SFAULT    = 4'd7;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/npc_mc_seq_if.sv
// Valid/ready memory bus shared by instruction fetch and load/store.
interface npc_mc_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_wen;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wmask;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/npc_bus_watchdog.sv
// Counts cycles spent waiting for a bus response and flags a timeout.
// TIMEOUT == 0 disables the watchdog entirely.
module npc_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,     // request accepted: a fresh wait begins
  input  logic en_i,      // waiting and no response this cycle
  output logic expired_o
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (TW < 1) ? 1 : TW;
  localparam logic [CW-1:0] LastCnt = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Wait-cycle counter, cleared at each request acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expiry only counts when no response arrived, so a late response wins.
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/npc_mc_seq.sv
// Multi-cycle fetch/execute sequencer: owns PC, instruction register and the
// single memory bus port; gates RF writeback and raises traps and halt.
module npc_mc_seq
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  npc_mc_seq_if.master      bus,
  output logic [XLEN-1:0]   pc,
  output logic [31:0]       inst,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic [XLEN-1:0]   dec_addr,
  input  logic [XLEN-1:0]   dec_wdata,
  input  logic [XLEN/8-1:0] dec_wmask,
  input  logic              dec_redirect,
  input  logic [XLEN-1:0]   dec_target,
  input  logic              dec_ebreak,
  input  logic [XLEN-1:0]   trap_vector,
  output logic              rf_wen_gate,
  output logic [XLEN-1:0]   load_data,
  output logic              commit,
  output logic              trap_valid,
  output logic [3:0]        trap_cause,
  output logic [XLEN-1:0]   trap_tval,
  output logic              halted
);
  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] load_data_q;

  logic wd_clr, wd_en, wd_expired;

  assign wd_clr = bus.req_valid && bus.req_ready;
  assign wd_en  = (state_q == StFetchWait || state_q == StMemWait) && !bus.rsp_valid;

  npc_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  assign pc        = pc_q;
  assign inst      = inst_q;
  assign load_data = load_data_q;

  // Per-state bus request, commit/writeback gating and trap detection.
  // Everything is forced low while reset is held so an abandoned
  // transaction cannot leak a trap or commit.
  always_comb begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wen   = 1'b0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    commit        = 1'b0;
    rf_wen_gate   = 1'b0;
    trap_valid    = 1'b0;
    trap_cause    = '0;
    trap_tval     = '0;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetchReq: begin
          if (pc_q[1:0] != 2'b00) begin
            trap_valid = 1'b1;
            trap_cause = CAUSE_IMISALIGN;
            trap_tval  = pc_q;
          end else begin
            bus.req_valid = 1'b1;
            bus.req_addr  = pc_q;
            bus.req_wmask = '1;
          end
        end
        StFetchWait: begin
          if ((bus.rsp_valid && bus.rsp_err) || wd_expired) begin
            trap_valid = 1'b1;
            trap_cause = CAUSE_IFAULT;
            trap_tval  = pc_q;
          end
        end
        StExec: begin
          if (dec_ebreak) begin
            commit = 1'b1;
          end else if (!dec_is_load && !dec_is_store) begin
            commit      = 1'b1;
            rf_wen_gate = 1'b1;
          end
        end
        StMemReq: begin
          bus.req_valid = 1'b1;
          bus.req_addr  = dec_addr;
          bus.req_wen   = dec_is_store;
          if (dec_is_store) begin
            bus.req_wdata = dec_wdata;
            bus.req_wmask = dec_wmask;
          end
        end
        StMemWait: begin
          if ((bus.rsp_valid && bus.rsp_err) || wd_expired) begin
            trap_valid = 1'b1;
            trap_cause = dec_is_store ? CAUSE_SFAULT : CAUSE_LFAULT;
            trap_tval  = dec_addr;
          end
        end
        StWb: begin
          commit      = 1'b1;
          rf_wen_gate = dec_is_load;
        end
        StHalt: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Sequencer FSM with PC, instruction and load-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetchReq;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      load_data_q <= '0;
    end else if (trap_valid) begin
      pc_q    <= trap_vector;
      state_q <= StFetchReq;
    end else begin
      case (state_q)
        StFetchReq: begin
          if (bus.req_ready) state_q <= StFetchWait;
        end
        StFetchWait: begin
          if (bus.rsp_valid) begin
            inst_q  <= bus.rsp_rdata[31:0];
            state_q <= StExec;
          end
        end
        StExec: begin
          if (dec_ebreak) begin
            state_q <= StHalt;
          end else if (dec_is_load || dec_is_store) begin
            state_q <= StMemReq;
          end else begin
            pc_q    <= dec_redirect ? dec_target : pc_q + XLEN'(4);
            state_q <= StFetchReq;
          end
        end
        StMemReq: begin
          if (bus.req_ready) state_q <= StMemWait;
        end
        StMemWait: begin
          if (bus.rsp_valid) begin
            load_data_q <= bus.rsp_rdata;
            state_q     <= StWb;
          end
        end
        StWb: begin
          pc_q    <= pc_q + XLEN'(4);
          state_q <= StFetchReq;
        end
        StHalt: ;
        default: state_q <= StFetchReq;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mc_seq.sv
// Directed bench for npc_mc_seq: the bench plays the memory bus and the
// decoder, with hand-computed expectations at each step.
module tb_npc_mc_seq;
  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst;
  logic            dec_is_load, dec_is_store, dec_redirect, dec_ebreak;
  logic [XLEN-1:0] dec_addr, dec_wdata, dec_target, trap_vector;
  logic [3:0]      dec_wmask;
  logic            rf_wen_gate, commit, trap_valid, halted;
  logic [XLEN-1:0] load_data, trap_tval;
  logic [3:0]      trap_cause;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  npc_mc_seq_if #(.XLEN(XLEN)) bus ();

  npc_mc_seq #(
    .XLEN     (XLEN),
    .RESET_PC (32'h8000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pc           (pc),
    .inst         (inst),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_addr     (dec_addr),
    .dec_wdata    (dec_wdata),
    .dec_wmask    (dec_wmask),
    .dec_redirect (dec_redirect),
    .dec_target   (dec_target),
    .dec_ebreak   (dec_ebreak),
    .trap_vector  (trap_vector),
    .rf_wen_gate  (rf_wen_gate),
    .load_data    (load_data),
    .commit       (commit),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_tval    (trap_tval),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next active edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point, half a period away from the active edge.
  task automatic sample();
    @(negedge clk);
  endtask

  // Fetch with ready=1 and a response one cycle after acceptance; ends in EXEC.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    bus.req_ready = 1'b1;
    sample();
    check("fetch_valid", 32'(bus.req_valid), 32'd1);
    check("fetch_addr", bus.req_addr, addr);
    check("fetch_wen", 32'(bus.req_wen), 32'd0);
    check("fetch_mask", 32'(bus.req_wmask), 32'hF);
    check("fetch_commit", 32'(commit), 32'd0);
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = word;
    sample();
    check("fwait_valid", 32'(bus.req_valid), 32'd0);
    check("fwait_trap", 32'(trap_valid), 32'd0);
    tick();
    bus.rsp_valid = 1'b0;
    check("fetch_inst", inst, word);
  endtask

  initial begin
    logic [31:0] pc_exp;
    rst = 1'b1;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_redirect = 1'b0; dec_ebreak = 1'b0;
    dec_addr = '0; dec_wdata = '0; dec_wmask = '0; dec_target = '0;
    trap_vector = 32'h8000_0200;

    // Reset
    tick();
    sample();
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    tick();
    rst = 1'b0;
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap", 32'(trap_valid), 32'd0);

    // Four ALU instructions, one commit per three cycles
    pc_exp = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      fetch(pc_exp, 32'h0010_0093);
      sample();
      check("alu_commit", 32'(commit), 32'd1);
      check("alu_rf_wen", 32'(rf_wen_gate), 32'd1);
      tick();
      pc_exp = pc_exp + 32'd4;
      check("alu_pc", pc, pc_exp);
    end
    check("alu_pc_final", pc, 32'h8000_0010);

    // Load with ready stalled two cycles and a response on the third wait cycle
    fetch(32'h8000_0010, 32'h0000_a083);
    dec_is_load = 1'b1;
    dec_addr    = 32'h8000_1000;
    dec_wdata   = 32'h5555_5555;
    dec_wmask   = 4'hF;
    sample();
    check("ld_exec_commit", 32'(commit), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.req_ready = (i == 2);
      sample();
      check("ld_req_valid", 32'(bus.req_valid), 32'd1);
      check("ld_req_addr", bus.req_addr, 32'h8000_1000);
      check("ld_req_wen", 32'(bus.req_wen), 32'd0);
      check("ld_req_wdata", bus.req_wdata, 32'd0);
      check("ld_req_mask", 32'(bus.req_wmask), 32'd0);
      tick();
    end
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rsp_valid = (i == 2);
      bus.rsp_rdata = 32'hDEAD_BEEF;
      sample();
      check("ld_wait_trap", 32'(trap_valid), 32'd0);
      check("ld_wait_commit", 32'(commit), 32'd0);
      tick();
    end
    bus.rsp_valid = 1'b0;
    sample();
    check("ld_data", load_data, 32'hDEAD_BEEF);
    check("ld_wb_rf_wen", 32'(rf_wen_gate), 32'd1);
    check("ld_wb_commit", 32'(commit), 32'd1);
    tick();
    dec_is_load = 1'b0;
    check("ld_pc", pc, 32'h8000_0014);

    // Taken branch, then a redirect to a misaligned target
    fetch(32'h8000_0014, 32'h0000_0063);
    dec_redirect = 1'b1;
    dec_target   = 32'h8000_0100;
    sample();
    check("br_commit", 32'(commit), 32'd1);
    tick();
    fetch(32'h8000_0100, 32'h0000_006f);
    dec_target = 32'h8000_0102;
    tick();
    dec_redirect = 1'b0;
    sample();
    check("mis_trap", 32'(trap_valid), 32'd1);
    check("mis_cause", 32'(trap_cause), 32'd0);
    check("mis_tval", trap_tval, 32'h8000_0102);
    check("mis_req_valid", 32'(bus.req_valid), 32'd0);
    check("mis_commit", 32'(commit), 32'd0);
    tick();
    check("mis_pc", pc, 32'h8000_0200);

    // Store answered with an error
    fetch(32'h8000_0200, 32'h0020_a023);
    dec_is_store = 1'b1;
    dec_addr     = 32'h8000_1004;
    dec_wdata    = 32'h1234_5678;
    dec_wmask    = 4'b1100;
    tick();
    bus.req_ready = 1'b1;
    sample();
    check("st_req_wen", 32'(bus.req_wen), 32'd1);
    check("st_req_wdata", bus.req_wdata, 32'h1234_5678);
    check("st_req_mask", 32'(bus.req_wmask), 32'hC);
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_err   = 1'b1;
    sample();
    check("st_trap", 32'(trap_valid), 32'd1);
    check("st_cause", 32'(trap_cause), 32'd7);
    check("st_tval", trap_tval, 32'h8000_1004);
    check("st_commit", 32'(commit), 32'd0);
    check("st_rf_wen", 32'(rf_wen_gate), 32'd0);
    tick();
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    dec_is_store  = 1'b0;
    sample();
    check("st_next_fetch", bus.req_addr, 32'h8000_0200);

    // Fetch timeout: trap on the fourth wait cycle
    trap_vector   = 32'h8000_0300;
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("to_no_trap", 32'(trap_valid), 32'd0);
      tick();
    end
    sample();
    check("to_trap", 32'(trap_valid), 32'd1);
    check("to_cause", 32'(trap_cause), 32'd1);
    check("to_tval", trap_tval, 32'h8000_0200);
    tick();
    check("to_pc", pc, 32'h8000_0300);

    // Response on the fourth wait cycle beats the timeout
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rsp_valid = (i == 3);
      bus.rsp_rdata = 32'h0010_0073;
      sample();
      check("late_no_trap", 32'(trap_valid), 32'd0);
      tick();
    end
    bus.rsp_valid = 1'b0;
    check("late_inst", inst, 32'h0010_0073);

    // ebreak: commit then halt with the bus idle
    dec_ebreak = 1'b1;
    sample();
    check("eb_commit", 32'(commit), 32'd1);
    check("eb_rf_wen", 32'(rf_wen_gate), 32'd0);
    tick();
    dec_ebreak = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_req_valid", 32'(bus.req_valid), 32'd0);
      check("halt_commit", 32'(commit), 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("unhalt_pc", pc, 32'h8000_0000);
    check("unhalt_halted", 32'(halted), 32'd0);

    // Reset during MEM_WAIT, then a stray response outside a wait state
    fetch(32'h8000_0000, 32'h0000_a083);
    dec_is_load = 1'b1;
    dec_addr    = 32'h8000_1000;
    tick();
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dec_is_load = 1'b0;
    check("mrst_pc", pc, 32'h8000_0000);
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'h0BAD_0BAD;
    sample();
    check("mrst_req_addr", bus.req_addr, 32'h8000_0000);
    check("mrst_trap", 32'(trap_valid), 32'd0);
    tick();
    bus.rsp_valid = 1'b0;
    check("mrst_inst", inst, 32'd0);
    check("mrst_load_data", load_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
